// File: rtl/keypad_entry_lock.sv
// Keypad password entry with failure counting and timed lockout.
// Checks debounced digits in order against a PASS_LEN-digit password.
module keypad_entry_lock #(
    parameter int DIGIT_W        = 4,
    parameter int PASS_LEN       = 12,
    parameter int MAX_FAILS      = 3,
    parameter int LOCKOUT_CYCLES = 1000,
    localparam int LEDW = PASS_LEN * DIGIT_W,
    localparam int DCW  = $clog2(PASS_LEN + 1),
    localparam int FCW  = (MAX_FAILS < 1) ? 1 : $clog2(MAX_FAILS + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [DIGIT_W-1:0] key_val,
    input  logic               key_press,
    input  logic [LEDW-1:0]    passd,
    output logic [LEDW-1:0]    led_digits,
    output logic [DCW-1:0]     digit_count,
    output logic [FCW-1:0]     fail_count,
    output logic               E,
    output logic               locked
);

    localparam int TW = $clog2(LOCKOUT_CYCLES + 1);

    // With lockout disabled the counter saturates at its encodable maximum
    localparam logic [FCW-1:0] FAIL_SAT =
        (MAX_FAILS == 0) ? {FCW{1'b1}} : FCW'(MAX_FAILS);

    typedef enum logic [1:0] {
        IDLE,
        ENTRY,
        SUCCESS,
        LOCKOUT
    } state_t;

    state_t             state, state_d;
    logic               key_prev;
    logic [TW-1:0]      timer, timer_d;
    logic [LEDW-1:0]    led_d;
    logic [DCW-1:0]     dcnt_d;
    logic [FCW-1:0]     fcnt_d, fcnt_inc;
    logic               e_d, lock_d;
    logic               press_evt;
    logic [DIGIT_W-1:0] exp_digit;

    // Password digit expected next, selected by the correct-digit count
    always_comb begin
        exp_digit = '0;
        for (int i = 0; i < PASS_LEN; i++) begin
            if (digit_count == DCW'(i)) begin
                exp_digit = passd[i*DIGIT_W +: DIGIT_W];
            end
        end
    end

    // Next-state and next-output logic for the entry FSM
    always_comb begin
        state_d   = state;
        led_d     = led_digits;
        dcnt_d    = digit_count;
        fcnt_d    = fail_count;
        e_d       = E;
        lock_d    = locked;
        timer_d   = timer;
        press_evt = key_press & ~key_prev;
        fcnt_inc  = (fail_count == FAIL_SAT) ? fail_count
                                             : fail_count + FCW'(1);
        unique case (state)
            IDLE: begin
                led_d   = '0;
                dcnt_d  = '0;
                e_d     = 1'b0;
                lock_d  = 1'b0;
                timer_d = '0;
                if (enable) begin
                    state_d = ENTRY;
                end
            end
            ENTRY: begin
                if (!enable) begin
                    state_d = IDLE;
                    led_d   = '0;
                    dcnt_d  = '0;
                end else if (press_evt) begin
                    if (key_val == exp_digit) begin
                        led_d  = {led_digits[LEDW-DIGIT_W-1:0], key_val};
                        dcnt_d = digit_count + DCW'(1);
                        if (digit_count == DCW'(PASS_LEN - 1)) begin
                            state_d = SUCCESS;
                            e_d     = 1'b1;
                            fcnt_d  = '0;
                        end
                    end else begin
                        led_d  = '0;
                        dcnt_d = '0;
                        fcnt_d = fcnt_inc;
                        if (MAX_FAILS != 0 &&
                            fcnt_inc == FCW'(MAX_FAILS)) begin
                            state_d = LOCKOUT;
                            lock_d  = 1'b1;
                            timer_d = TW'(LOCKOUT_CYCLES);
                        end
                    end
                end
            end
            SUCCESS: begin
                if (!enable) begin
                    state_d = IDLE;
                    e_d     = 1'b0;
                    led_d   = '0;
                    dcnt_d  = '0;
                end
            end
            LOCKOUT: begin
                led_d  = '0;
                dcnt_d = '0;
                if (timer == TW'(1)) begin
                    lock_d  = 1'b0;
                    fcnt_d  = '0;
                    timer_d = '0;
                    state_d = enable ? ENTRY : IDLE;
                end else begin
                    timer_d = timer - TW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, edge-detect and registered output update
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            key_prev    <= 1'b0;
            timer       <= '0;
            led_digits  <= '0;
            digit_count <= '0;
            fail_count  <= '0;
            E           <= 1'b0;
            locked      <= 1'b0;
        end else begin
            state       <= state_d;
            key_prev    <= key_press;
            timer       <= timer_d;
            led_digits  <= led_d;
            digit_count <= dcnt_d;
            fail_count  <= fcnt_d;
            E           <= e_d;
            locked      <= lock_d;
        end
    end

endmodule

// File: tb/tb_keypad_entry_lock.sv
// Bench for keypad_entry_lock: directed test-plan scenarios plus
// randomized presses, all compared against a queue-based reference.
module tb_keypad_entry_lock;

    localparam int DW = 4;
    localparam int PL = 4;
    localparam int MF = 2;
    localparam int LC = 8;
    localparam int LEDW = PL * DW;
    localparam int DCW = $clog2(PL + 1);
    localparam int FCW = $clog2(MF + 1);

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            enable = 1'b1;
    logic [DW-1:0]   key_val = '0;
    logic            key_press = 1'b0;
    logic [LEDW-1:0] passd = 16'h4321;
    logic [LEDW-1:0] led_digits;
    logic [DCW-1:0]  digit_count;
    logic [FCW-1:0]  fail_count;
    logic            E;
    logic            locked;

    int n_tests = 0;
    int n_fail = 0;

    // Reference: q holds correctly entered digits, q[0] most recent
    int q[$];
    bit m_active, m_done, m_prev;
    int m_fails, m_lock;

    keypad_entry_lock #(
        .DIGIT_W(DW), .PASS_LEN(PL),
        .MAX_FAILS(MF), .LOCKOUT_CYCLES(LC)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .key_val(key_val), .key_press(key_press), .passd(passd),
        .led_digits(led_digits), .digit_count(digit_count),
        .fail_count(fail_count), .E(E), .locked(locked)
    );

    // Free-running clock
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    function automatic int pw_digit(input int idx);
        logic [LEDW-1:0] s;
        s = passd >> (idx * DW);
        return int'(s[DW-1:0]);
    endfunction

    task automatic model_reset();
        q.delete();
        m_active = 0;
        m_done = 0;
        m_prev = 0;
        m_fails = 0;
        m_lock = 0;
    endtask

    task automatic model_step();
        bit ev;
        ev = key_press && !m_prev;
        m_prev = key_press;
        if (m_lock > 0) begin
            m_lock--;
            if (m_lock == 0) begin
                m_fails = 0;
                m_active = enable;
            end
        end else if (m_done) begin
            if (!enable) begin
                m_done = 0;
                m_active = 0;
                q.delete();
            end
        end else if (!m_active) begin
            if (enable) m_active = 1;
        end else if (!enable) begin
            m_active = 0;
            q.delete();
        end else if (ev) begin
            if (int'(key_val) == pw_digit(q.size())) begin
                q.push_front(int'(key_val));
                if (q.size() == PL) begin
                    m_done = 1;
                    m_fails = 0;
                end
            end else begin
                q.delete();
                if (m_fails < MF) m_fails++;
                if (m_fails == MF) m_lock = LC;
            end
        end
    endtask

    task automatic check_all();
        logic [LEDW-1:0] exp_led;
        exp_led = '0;
        for (int i = 0; i < q.size(); i++) begin
            exp_led[i*DW +: DW] = q[i][DW-1:0];
        end
        chk("led", led_digits, exp_led);
        chk("dcnt", digit_count, q.size());
        chk("fcnt", fail_count, m_fails);
        chk("E", E, m_done);
        chk("locked", locked, m_lock > 0);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic press(input int d, input int hold);
        key_val = DW'(d);
        key_press = 1'b1;
        repeat (hold) tick();
        key_press = 1'b0;
        tick();
    endtask

    task automatic restart();
        enable = 1'b0;
        tick();
        enable = 1'b1;
        tick();
    endtask

    task automatic async_reset();
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        model_reset();
        chk("rst_led", led_digits, 0);
        chk("rst_dcnt", digit_count, 0);
        chk("rst_fcnt", fail_count, 0);
        chk("rst_E", E, 0);
        chk("rst_locked", locked, 0);
        #1 reset = 1'b0;
        key_press = 1'b0;
        tick();
    endtask

    initial begin
        model_reset();
        #3;
        chk("por_led", led_digits, 0);
        chk("por_E", E, 0);
        chk("por_locked", locked, 0);
        @(negedge clk);
        reset = 1'b0;
        tick();

        // Correct entry
        press(1, 1); press(2, 1); press(3, 1);
        key_val = 4'd4;
        key_press = 1'b1;
        tick();
        chk("ok_E", E, 1);
        key_press = 1'b0;
        tick();
        chk("ok_led", led_digits, 16'h1234);
        chk("ok_dcnt", digit_count, 4);
        chk("ok_fcnt", fail_count, 0);
        enable = 1'b0;
        tick();
        chk("succ_dis_E", E, 0);
        enable = 1'b1;
        tick();

        // Held key gives one event
        press(1, 20); press(2, 1);
        chk("held_dcnt", digit_count, 2);
        restart();

        // Mismatch then recovery
        press(1, 1); press(2, 1); press(7, 1);
        chk("mm_led", led_digits, 0);
        chk("mm_fcnt", fail_count, 1);
        chk("mm_locked", locked, 0);
        press(1, 1); press(2, 1); press(3, 1); press(4, 1);
        chk("rec_E", E, 1);
        chk("rec_fcnt", fail_count, 0);
        restart();

        // Lockout ignores presses and lasts LC cycles
        press(9, 1); press(9, 1);
        chk("lk_on", locked, 1);
        press(1, 1); press(2, 1); press(3, 1); press(4, 1);
        chk("lk_off", locked, 0);
        chk("lk_dcnt", digit_count, 0);
        chk("lk_fcnt", fail_count, 0);
        press(1, 1);
        chk("lk_entry", digit_count, 1);
        restart();

        // Disable beats a simultaneous press
        press(1, 1); press(2, 1);
        enable = 1'b0;
        key_val = 4'd3;
        key_press = 1'b1;
        tick();
        chk("dis_led", led_digits, 0);
        chk("dis_dcnt", digit_count, 0);
        key_press = 1'b0;
        enable = 1'b1;
        tick();
        tick();

        // Async reset mid-lockout and mid-entry
        press(9, 1); press(9, 1); tick(); tick();
        async_reset();
        press(1, 1); press(2, 1);
        async_reset();
        press(1, 1); press(2, 1); press(3, 1); press(4, 1);
        chk("post_rst_E", E, 1);
        restart();

        // Randomized presses, enable drops, password changes
        for (int it = 0; it < 500; it++) begin
            int r;
            int d;
            r = $urandom_range(0, 99);
            if (r == 99) begin
                async_reset();
            end else if (r < 5 || (m_done && r < 40)) begin
                enable = 1'b0;
                repeat ($urandom_range(1, 3)) tick();
                enable = 1'b1;
                tick();
            end else if (r < 9) begin
                passd = LEDW'($urandom);
                tick();
            end else begin
                if (r % 4 != 0 && q.size() < PL) d = pw_digit(q.size());
                else d = $urandom_range(0, 15);
                press(d, $urandom_range(1, 4));
                repeat ($urandom_range(0, 2)) tick();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
